medidor_pulso: RTL
==================

MEDIDOR_PULSO -- requirements
Module: medidor_pulso

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the measurement counters.
REQ-002 The block SHALL have parameter SYNC_N, default 2, giving the number of synchronizer flops on y_in (minimum 2).
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  measurement enable.
REQ-006 Port y_in  input  1  output of the 3-input AND stage; asynchronous to clk.
REQ-007 Port res_ready  input  1  consumer accepts result.
REQ-008 Port res_valid  output  1  result available.
REQ-009 Port pulse_width  output  CNT_W  clk cycles y was high.
REQ-010 Port pulse_period  output  CNT_W  clk cycles from rise to next rise.
REQ-011 Port overflow  output  1  result is saturated, not exact.
REQ-012 Port meas_count  output  8  number of accepted results, wrapping.

Function
REQ-013 y_in SHALL pass through SYNC_N flops to give y_s; one further flop gives y_d; rise = y_s & ~y_d; fall = ~y_s & y_d.
REQ-014 FSM states SHALL be IDLE, ARM, HIGH, LOW, REPORT.
REQ-015 IDLE: go to ARM when en=1; counters held at 0.
REQ-016 ARM: wait for rise; on rise go to HIGH with width_cnt=1, per_cnt=1.
REQ-017 HIGH: each cycle width_cnt and per_cnt increment; on fall go to LOW; width_cnt stops and per_cnt increments.
REQ-018 LOW: per_cnt increments each cycle; on rise latch pulse_width=width_cnt and pulse_period=per_cnt, set res_valid=1, overflow=0, and go to REPORT.
REQ-019 Counters SHALL saturate at 2^CNT_W-1; if per_cnt reaches saturation in HIGH or LOW, latch current values, set overflow=1 and res_valid=1, and go to REPORT.
REQ-020 REPORT: pulse_width, pulse_period, overflow and res_valid SHALL be held stable until res_valid & res_ready at a clk edge.
REQ-021 On transfer, res_valid SHALL be 0 next cycle and meas_count SHALL increment (255 wraps to 0); next state SHALL be ARM if en=1, else IDLE.
REQ-022 A rise during REPORT SHALL be ignored; the next measurement starts at the first rise seen in ARM.
REQ-023 en=0 in ARM, HIGH or LOW SHALL return to IDLE next cycle and discard the partial measurement with no result.
REQ-024 en=0 in REPORT SHALL NOT drop the pending result.
REQ-025 Latency: res_valid SHALL rise on the clk edge at which the terminating rise is detected (SYNC_N+1 cycles after the y_in edge).
REQ-026 res_valid may be combinationally observed but SHALL NOT depend combinationally on res_ready.

Reset
REQ-027 While reset=1, the block SHALL asynchronously force state IDLE, all synchronizer flops and y_d to 0, counters to 0, res_valid=0, pulse_width=0, pulse_period=0, overflow=0 and meas_count=0.
REQ-028 Reset asserted mid-measurement or in REPORT SHALL discard everything without producing a transfer.
REQ-029 After reset release, a y_in already high SHALL NOT produce a rise until it has gone low then high again.

Structure
REQ-030 Package medidor_pkg SHALL hold the state enumeration and the default values of CNT_W and SYNC_N.
REQ-031 The synchronizer SHALL be a sub-module sincronizador (parameter SYNC_N, ports clk, reset, d, q).
REQ-032 Everything else SHALL be in one module.

Verification
REQ-033 y_in high 3 cycles, low 5 cycles, repeating, with en=1 and res_ready=1 -> result width=3, period=8, overflow=0; meas_count increments once per result.
REQ-034 Same stimulus with res_ready=0 for 20 cycles -> res_valid stays 1 and values are stable; one transfer occurs when ready rises.
REQ-035 y_in held low for 300 cycles after a 2-cycle pulse (CNT_W=8) -> width=2, period=255, overflow=1.
REQ-036 en dropped during HIGH -> no res_valid; IDLE next cycle; the next full pulse after en=1 measures correctly.
REQ-037 Reset asserted while in LOW with a pending count -> all outputs 0 immediately; y_in already high at release gives no result until a fresh rise.
REQ-038 Drive y_in from the AND stage with a=clk/2, b=clk/4 and c=clk/8 toggles -> width=2, period=16 (clk units of the bench toggle period).

Source files
------------

// File: rtl/medidor_pkg.sv
// Shared definitions for the pulse width/period meter: FSM encoding and parameter defaults.
package medidor_pkg;

   localparam int unsigned CNT_W_DEF  = 8;
   localparam int unsigned SYNC_N_DEF = 2;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      HIGH,
      LOW,
      REPORT
   } estado_t;

endpackage

// File: rtl/sincronizador.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sincronizador
   import medidor_pkg::*;
#(
   parameter int unsigned SYNC_N = SYNC_N_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_N-1:0] etapa;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) etapa <= '0;
      else       etapa <= {etapa[SYNC_N-2:0], d};
   end

   assign q = etapa[SYNC_N-1];

endmodule

// File: rtl/medidor_pulso.sv
// Measures high time and rise-to-rise period of a synchronized pulse, in clk cycles,
// and offers each result through a valid/ready handshake.
module medidor_pulso
   import medidor_pkg::*;
#(
   parameter int unsigned CNT_W  = CNT_W_DEF,
   parameter int unsigned SYNC_N = SYNC_N_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             y_in,
   input  logic             res_ready,
   output logic             res_valid,
   output logic [CNT_W-1:0] pulse_width,
   output logic [CNT_W-1:0] pulse_period,
   output logic             overflow,
   output logic [7:0]       meas_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   estado_t           state, state_next;
   logic              y_s, y_d, primed, sync_ok;
   logic              rise, fall;
   logic [SYNC_N-1:0] fill;
   logic [CNT_W-1:0]  width_cnt, per_cnt;
   logic              per_sat, capture, xfer, sat_result;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   sincronizador #(.SYNC_N(SYNC_N)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (y_in),
      .q     (y_s)
   );

   // The synchronizer powers up at 0, so an input already high at release would look
   // like a rise. Edges count only after a genuine low has come through the chain.
   assign sync_ok = fill[SYNC_N-1];
   assign rise    = y_s & ~y_d & primed;
   assign fall    = ~y_s & y_d;
   assign per_sat = (per_cnt == CNT_MAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_d    <= 1'b0;
         fill   <= '0;
         primed <= 1'b0;
      end else begin
         y_d  <= y_s;
         fill <= {fill[SYNC_N-2:0], 1'b1};
         if (sync_ok && !y_s) primed <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (en) state_next = ARM;
         ARM: begin
            if (!en)       state_next = IDLE;
            else if (rise) state_next = HIGH;
         end
         HIGH: begin
            if (!en)          state_next = IDLE;
            else if (per_sat) state_next = REPORT;
            else if (fall)    state_next = LOW;
         end
         LOW: begin
            if (!en)                  state_next = IDLE;
            else if (rise || per_sat) state_next = REPORT;
         end
         REPORT:  if (res_ready) state_next = en ? ARM : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      res_valid  = (state == REPORT);
      xfer       = (state == REPORT) && res_ready;
      capture    = (state != REPORT) && (state_next == REPORT);
      // A terminating rise wins over saturation on the same cycle: the count is still exact.
      sat_result = !((state == LOW) && rise);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         width_cnt    <= '0;
         per_cnt      <= '0;
         pulse_width  <= '0;
         pulse_period <= '0;
         overflow     <= 1'b0;
         meas_count   <= '0;
      end else begin
         if (state_next == HIGH || state_next == LOW) begin
            if (state == ARM) begin
               width_cnt <= {{(CNT_W-1){1'b0}}, 1'b1};
               per_cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               per_cnt <= sat_inc(per_cnt);
               if (state == HIGH && !fall) width_cnt <= sat_inc(width_cnt);
            end
         end else begin
            width_cnt <= '0;
            per_cnt   <= '0;
         end

         if (capture) begin
            pulse_width  <= width_cnt;
            pulse_period <= per_cnt;
            overflow     <= sat_result;
         end

         if (xfer) meas_count <= meas_count + 8'd1;
      end
   end

endmodule
